stage3_writeback: RTL
=====================

// Module: stage3_writeback
// PURPOSE
//   Pipeline stage directly downstream of the execute/memory stage. Registers the executed instruction,
//   selects writeback data (ALU result, extended load data, PC+4, CSR read value), drives the regfile
//   write port and the forwarding triple (wb_data_w, rwe_w, rd_w) fed back to execute, and owns the CSRs.
// PARAMETERS
//   RESET_PC   32'h0000_2000  pipeline-register PC value after reset
//   NOP_INST   32'h0000_0013  pipeline-register instruction after reset (addi x0,x0,0)
// PORTS
//   clk          in   1   clock; all state updates on posedge
//   reset        in   1   asynchronous, active-low reset (0 = in reset)
//   stall        in   1   global stall; 1 = hold all pipeline/CSR state
//   valid_x      in   1   execute stage holds a real (non-bubble) instruction
//   pc_x         in   32  PC of instruction in execute
//   inst_x       in   32  instruction in execute
//   alu_out_x    in   32  execute ALU result
//   csr_din_x    in   32  CSR write operand from execute (forwarded rs1 data, or zero-extended zimm)
//   dmem_dout    in   32  sign/zero-extended load data, valid after posedge for the registered load
//   wb_data_w    out  32  writeback data (regfile write data and forwarding data)
//   rwe_w        out  1   regfile write enable
//   rd_w         out  5   regfile destination index
//   csr_tohost   out  32  current value of CSR 0x51E
// BEHAVIOUR
//   - Pipe regs {valid_w, pc_w, inst_w, alu_w, csr_din_w}: posedge with stall=0 load *_x; stall=1 hold.
//   - Reset (async assert, sync-safe release): valid_w=0, pc_w=RESET_PC, inst_w=NOP_INST, alu_w=0,
//     csr_din_w=0, tohost=0. Outputs during reset: rwe_w=0, rd_w=0, wb_data_w=0, csr_tohost=0.
//   - Latency: one cycle; instruction sampled at edge N drives writeback throughout cycle N..N+1.
//   - rd_w = inst_w[11:7]. rwe_w = valid_w & ~stall & writes_rd & (rd_w != 0); writes_rd for
//     OP, OP-IMM, LUI, AUIPC, JAL, JALR, LOAD, SYSTEM csrrw(001)/csrrwi(101). Branch/STORE/other = 0.
//   - wb_data_w mux: LOAD -> dmem_dout; JAL/JALR -> pc_w + 4 (mod 2^32); csrrw/csrrwi -> old value of
//     CSR inst_w[31:20]; all others -> alu_w. Unimplemented CSR addresses read 0, writes ignored.
//   - CSR write: posedge with valid_w=1, stall=0, SYSTEM csrrw/csrrwi, addr 12'h51E -> tohost <= csr_din_w.
//     Read returns pre-write value (read-before-write in same cycle).
//   - Stall: no CSR/counter-instret update, rwe_w forced 0; load data is only written on the unstalled
//     cycle. Bubbles (valid_w=0) never write regfile or CSRs regardless of inst_w contents.
//   - Reset mid-operation: pending writeback is discarded; no regfile write or CSR write on that edge.
// CONFIGURATION
//   CSR_COUNTERS_EN defined: 32-bit cycle (0xC00) and instret (0xC02) CSRs, reset 0, read-only.
//     cycle +1 every posedge out of reset (stalled or not); instret +1 on posedge with valid_w=1 and
//     stall=0; both wrap 32'hFFFF_FFFF -> 0. Read via csrrw/csrrwi returns pre-increment value.
//   Undefined: 0xC00/0xC02 read 0; no counter flops synthesised.
// STRUCTURE
//   - Shared constants header/package: RV32 opcode, funct3 and CSR address constants (OPC_LOAD,
//     OPC_JAL, OPC_JALR, OPC_SYSTEM, CSR_TOHOST, CSR_CYCLE, CSR_INSTRET); shared with execute decoders.
//   - One sub-module: csr_file (address decode, tohost, optional counters, read mux); writeback mux,
//     pipe regs and rwe/rd decode stay in stage3_writeback.
// TESTING
//   1. Reset held low 3 cycles, release: rwe_w=0, rd_w=0, csr_tohost=0 until first valid instruction.
//   2. addi x5,x0,7 (alu_out_x=7, valid_x=1), one edge -> rd_w=5, rwe_w=1, wb_data_w=7.
//   3. lw x6 then dmem_dout=32'hFFFF_FF80 after edge -> wb_data_w=32'hFFFF_FF80, rd_w=6; stall=1 for
//      2 cycles meanwhile -> rwe_w=0 during stall, 1 on release, data unchanged.
//   4. jal x1 at pc_x=32'h0000_2010 -> wb_data_w=32'h0000_2014, rd_w=1; at pc 32'hFFFF_FFFC -> 0.
//   5. csrrw x0,0x51E with csr_din_x=1 -> csr_tohost=1 after edge; csrrw x7,0x51E, din=2 -> x7 gets 1,
//      tohost=2; same with valid_x=0 or stall=1 -> tohost unchanged; addi to x0 -> rwe_w=0.
//   6. CSR_COUNTERS_EN: 10 cycles incl. 3 stalled, 4 valid unstalled instructions -> cycle=10,
//      instret=4; preload 32'hFFFF_FFFF via force -> wraps to 0; without macro csrrw x8,0xC00 -> x8=0.

Source files
------------

// File: rtl/stage3_writeback_pkg.sv
// Shared RV32 decode constants for the execute and writeback stages.
//
// Contents:
//   opcode_e      - major opcodes used by the writeback stage decode
//   F3_CSRRW/I    - SYSTEM funct3 values for csrrw / csrrwi
//   CSR_*         - CSR addresses implemented by csr_file
//   csr_rw_op()   - true for a csrrw or csrrwi instruction

package stage3_writeback_pkg;

    typedef enum logic [6:0] {
        OPC_LOAD   = 7'b0000011,
        OPC_OP_IMM = 7'b0010011,
        OPC_AUIPC  = 7'b0010111,
        OPC_STORE  = 7'b0100011,
        OPC_OP     = 7'b0110011,
        OPC_LUI    = 7'b0110111,
        OPC_BRANCH = 7'b1100011,
        OPC_JALR   = 7'b1100111,
        OPC_JAL    = 7'b1101111,
        OPC_SYSTEM = 7'b1110011
    } opcode_e;

    localparam logic [2:0] F3_CSRRW  = 3'b001;
    localparam logic [2:0] F3_CSRRWI = 3'b101;

    localparam logic [11:0] CSR_TOHOST  = 12'h51E;
    localparam logic [11:0] CSR_CYCLE   = 12'hC00;
    localparam logic [11:0] CSR_INSTRET = 12'hC02;

    function automatic logic csr_rw_op(input logic [6:0] opcode, input logic [2:0] funct3);
        return (opcode == OPC_SYSTEM) && ((funct3 == F3_CSRRW) || (funct3 == F3_CSRRWI));
    endfunction

endpackage

// File: rtl/stage3_writeback_csr_file.sv
// CSR file owned by the writeback stage: address decode, tohost register,
// optional cycle/instret counters and the read mux.
//
// Configuration:
//   CSR_COUNTERS_EN  defined   -> read-only 32-bit cycle (0xC00) and instret (0xC02)
//                    undefined -> those addresses read 0 and no counter flops exist
//
// Ports:
//   clk        in   clock
//   reset      in   asynchronous active-low reset
//   csr_we     in   fully qualified CSR write strobe (valid, unstalled csrrw/csrrwi)
//   retire     in   an instruction leaves writeback this edge (valid and unstalled)
//   csr_addr   in   12-bit CSR address
//   csr_wdata  in   CSR write data
//   csr_rdata  out  pre-write / pre-increment value of the addressed CSR
//   tohost     out  current tohost value

module csr_file
    import stage3_writeback_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        csr_we,
    input  logic        retire,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic [31:0] tohost
);

    logic [31:0] tohost_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tohost_q <= 32'h0;
        end else if (csr_we && (csr_addr == CSR_TOHOST)) begin
            tohost_q <= csr_wdata;
        end
    end

    assign tohost = tohost_q;

`ifdef CSR_COUNTERS_EN
    logic [31:0] cycle_q;
    logic [31:0] instret_q;

    // Counters are read-only: csr_we never touches them. Both wrap naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_q   <= 32'h0;
            instret_q <= 32'h0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
            if (retire) begin
                instret_q <= instret_q + 32'd1;
            end
        end
    end

    always_comb begin
        csr_rdata = 32'h0;
        case (csr_addr)
            CSR_TOHOST:  csr_rdata = tohost_q;
            CSR_CYCLE:   csr_rdata = cycle_q;
            CSR_INSTRET: csr_rdata = instret_q;
            default:     csr_rdata = 32'h0;
        endcase
    end
`else
    logic unused_retire;
    assign unused_retire = retire;

    always_comb begin
        csr_rdata = 32'h0;
        if (csr_addr == CSR_TOHOST) begin
            csr_rdata = tohost_q;
        end
    end
`endif

endmodule

// File: rtl/stage3_writeback.sv
// Writeback pipeline stage. Registers the instruction leaving execute/memory,
// selects writeback data, drives the regfile write port / forwarding triple
// and hosts the CSR file.
//
// Configuration: CSR_COUNTERS_EN enables the cycle/instret CSRs in csr_file.
//
// Ports:
//   clk          in   clock
//   reset        in   asynchronous active-low reset
//   stall        in   global stall, holds all pipeline and CSR state
//   valid_x      in   execute holds a real instruction
//   pc_x         in   PC of the instruction in execute
//   inst_x       in   instruction in execute
//   alu_out_x    in   execute ALU result
//   csr_din_x    in   CSR write operand from execute
//   dmem_dout    in   extended load data for the registered load
//   wb_data_w    out  writeback / forwarding data
//   rwe_w        out  regfile write enable
//   rd_w         out  regfile destination index
//   csr_tohost   out  current tohost CSR value

module stage3_writeback
    import stage3_writeback_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_2000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        valid_x,
    input  logic [31:0] pc_x,
    input  logic [31:0] inst_x,
    input  logic [31:0] alu_out_x,
    input  logic [31:0] csr_din_x,
    input  logic [31:0] dmem_dout,
    output logic [31:0] wb_data_w,
    output logic        rwe_w,
    output logic [4:0]  rd_w,
    output logic [31:0] csr_tohost
);

    logic        valid_w;
    logic [31:0] pc_w;
    logic [31:0] inst_w;
    logic [31:0] alu_w;
    logic [31:0] csr_din_w;

    logic [6:0]  opcode_w;
    logic [2:0]  funct3_w;
    logic        is_csr_rw;
    logic        writes_rd;
    logic        csr_we;
    logic        retire;
    logic [31:0] csr_rdata;
    logic        unused_rs1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_w   <= 1'b0;
            pc_w      <= RESET_PC;
            inst_w    <= NOP_INST;
            alu_w     <= 32'h0;
            csr_din_w <= 32'h0;
        end else if (!stall) begin
            valid_w   <= valid_x;
            pc_w      <= pc_x;
            inst_w    <= inst_x;
            alu_w     <= alu_out_x;
            csr_din_w <= csr_din_x;
        end
    end

    assign opcode_w  = inst_w[6:0];
    assign funct3_w  = inst_w[14:12];
    assign rd_w      = inst_w[11:7];
    assign is_csr_rw = csr_rw_op(opcode_w, funct3_w);

    // The rs1 field is consumed in execute; writeback has no use for it.
    assign unused_rs1 = ^inst_w[19:15];

    always_comb begin
        writes_rd = 1'b0;
        case (opcode_w)
            OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC,
            OPC_JAL, OPC_JALR, OPC_LOAD: writes_rd = 1'b1;
            OPC_SYSTEM:                  writes_rd = is_csr_rw;
            default:                     writes_rd = 1'b0;
        endcase
    end

    // Bubbles and stalled cycles never commit; x0 is never written.
    assign retire = valid_w & ~stall;
    assign rwe_w  = retire & writes_rd & (rd_w != 5'd0);
    assign csr_we = retire & is_csr_rw;

    always_comb begin
        wb_data_w = alu_w;
        if (opcode_w == OPC_LOAD) begin
            wb_data_w = dmem_dout;
        end else if ((opcode_w == OPC_JAL) || (opcode_w == OPC_JALR)) begin
            wb_data_w = pc_w + 32'd4;
        end else if (is_csr_rw) begin
            wb_data_w = csr_rdata;
        end
    end

    csr_file u_csr (
        .clk       (clk),
        .reset     (reset),
        .csr_we    (csr_we),
        .retire    (retire),
        .csr_addr  (inst_w[31:20]),
        .csr_wdata (csr_din_w),
        .csr_rdata (csr_rdata),
        .tohost    (csr_tohost)
    );

endmodule
